// File: rtl/mux_scan_inv.sv
// N-channel selector with per-channel output inversion, a registered output,
// and manual or auto-scan channel selection.
module mux_scan_inv #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned NCH      = 4,
  parameter  int unsigned SCAN_DIV = 4,
  localparam int unsigned SELW     = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic [NCH-1:0]         inv_mask,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [SELW-1:0]        cur_ch,
  output logic                   wrap
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SELW-1:0] LastCh = SELW'(NCH - 1);
  localparam logic [DW-1:0]   LastDw = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   scan_ch_q, scan_ch_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [SELW-1:0]   ch_base;
  logic [DW-1:0]     dw_base;
  logic [SELW-1:0]   ch_sel;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  dout_q;
  logic [SELW-1:0]   cur_ch_q;
  logic              valid_q, wrap_q, wrap_d;

  // Next state, channel choice and scan-counter advance.
  always_comb begin
    state_d   = state_q;
    scan_ch_d = scan_ch_q;
    dwell_d   = dwell_q;
    wrap_d    = 1'b0;
    ch_base   = scan_ch_q;
    dw_base   = dwell_q;
    ch_sel    = scan_ch_q;
    if (!en) begin
      state_d = StIdle;
    end else if (!mode) begin
      state_d = StManual;
      ch_sel  = (sel > LastCh) ? LastCh : sel;
    end else begin
      state_d = StScan;
      // Entering scan from manual restarts at channel 0; from idle it resumes.
      if (state_q == StManual) begin
        ch_base = '0;
        dw_base = '0;
      end
      ch_sel = ch_base;
      wrap_d = (ch_base == LastCh) && (dw_base == LastDw);
      if (dw_base == LastDw) begin
        dwell_d   = '0;
        scan_ch_d = (ch_base == LastCh) ? '0 : ch_base + 1'b1;
      end else begin
        dwell_d   = dw_base + 1'b1;
        scan_ch_d = ch_base;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel == SELW'(k)) begin
        sel_data = din[k*WIDTH +: WIDTH] ^ {WIDTH{inv_mask[k]}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      scan_ch_q <= '0;
      dwell_q   <= '0;
      dout_q    <= '0;
      cur_ch_q  <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_ch_q <= scan_ch_d;
      dwell_q   <= dwell_d;
      valid_q   <= en;
      wrap_q    <= wrap_d;
      if (en) begin
        dout_q   <= sel_data;
        cur_ch_q <= ch_sel;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign cur_ch     = cur_ch_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_mux_scan_inv.sv
// Randomized scoreboard bench for mux_scan_inv: a 4-channel/dwell-2 instance
// and a 3-channel/dwell-1 instance share control inputs.
module tb_mux_scan_inv;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [1:0] c;
    logic       w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] din = '0;
  logic [3:0]  inv = '0;

  logic [7:0] dout_a, dout_b;
  logic [1:0] cur_a, cur_b;
  logic       valid_a, valid_b, wrap_a, wrap_b;

  int checks = 0;
  int failures = 0;
  logic mon_on = 1'b0;

  exp_t qa[$];
  exp_t qb[$];

  // Model state per instance: kind 0=idle 1=manual 2=scan, pos = linear scan position.
  int         m_kind[2];
  int         m_pos[2];
  logic [7:0] m_dout[2];
  int         m_cur[2];
  logic       m_valid[2];
  logic       m_wrap[2];
  int         nch_of[2]  = '{4, 3};
  int         sdiv_of[2] = '{2, 1};

  always #5 clk = ~clk;

  mux_scan_inv #(.WIDTH(8), .NCH(4), .SCAN_DIV(2)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din),
    .inv_mask(inv), .dout(dout_a), .dout_valid(valid_a), .cur_ch(cur_a), .wrap(wrap_a)
  );

  mux_scan_inv #(.WIDTH(8), .NCH(3), .SCAN_DIV(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din[23:0]),
    .inv_mask(inv[2:0]), .dout(dout_b), .dout_valid(valid_b), .cur_ch(cur_b), .wrap(wrap_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan_val(input int ch);
    logic [7:0] v;
    v = din[ch*8 +: 8];
    return inv[ch] ? ~v : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = 0; m_pos[i] = 0; m_dout[i] = '0;
      m_cur[i] = 0; m_valid[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    exp_t e;
    int   ch;
    int   span;
    span = nch_of[i] * sdiv_of[i];
    if (!en) begin
      m_valid[i] = 1'b0;
      m_wrap[i]  = 1'b0;
      m_kind[i]  = 0;
    end else if (!mode) begin
      ch = (int'(sel) >= nch_of[i]) ? nch_of[i] - 1 : int'(sel);
      m_dout[i] = chan_val(ch); m_cur[i] = ch;
      m_valid[i] = 1'b1; m_wrap[i] = 1'b0; m_kind[i] = 1;
    end else begin
      if (m_kind[i] == 1) m_pos[i] = 0;
      ch = m_pos[i] / sdiv_of[i];
      m_dout[i] = chan_val(ch); m_cur[i] = ch; m_valid[i] = 1'b1;
      m_wrap[i] = (m_pos[i] == span - 1);
      m_pos[i]  = (m_pos[i] + 1) % span;
      m_kind[i] = 2;
    end
    e.d = m_dout[i]; e.v = m_valid[i]; e.c = 2'(m_cur[i]); e.w = m_wrap[i];
    if (i == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic cycle(input logic e, input logic m, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] iv);
    @(negedge clk);
    en = e; mode = m; sel = s; din = d; inv = iv;
    model_step(0);
    model_step(1);
    mon_on = 1'b1;
  endtask

  task automatic check_out(input int i);
    exp_t e;
    if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
      checks++; failures++;
      $display("FAIL scoreboard_underflow inst=%0d actual=empty required=entry", i);
      return;
    end
    if (i == 0) begin
      e = qa.pop_front();
      chk("a_dout", 32'(dout_a), 32'(e.d)); chk("a_valid", 32'(valid_a), 32'(e.v));
      chk("a_cur_ch", 32'(cur_a), 32'(e.c)); chk("a_wrap", 32'(wrap_a), 32'(e.w));
    end else begin
      e = qb.pop_front();
      chk("b_dout", 32'(dout_b), 32'(e.d)); chk("b_valid", 32'(valid_b), 32'(e.v));
      chk("b_cur_ch", 32'(cur_b), 32'(e.c)); chk("b_wrap", 32'(wrap_b), 32'(e.w));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      check_out(0);
      check_out(1);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_dout_a"}, 32'(dout_a), 0);  chk({tag, "_valid_a"}, 32'(valid_a), 0);
    chk({tag, "_cur_a"}, 32'(cur_a), 0);    chk({tag, "_wrap_a"}, 32'(wrap_a), 0);
    chk({tag, "_dout_b"}, 32'(dout_b), 0);  chk({tag, "_valid_b"}, 32'(valid_b), 0);
    chk({tag, "_cur_b"}, 32'(cur_b), 0);    chk({tag, "_wrap_b"}, 32'(wrap_b), 0);
  endtask

  initial begin
    int exp_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [31:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 2'd0, $urandom, 4'($urandom));

    // Manual select with inversion, then inversion removed.
    d = $urandom;
    d[23:16] = 8'hA5;
    cycle(1'b1, 1'b0, 2'd2, d, 4'b0100);
    @(posedge clk); #2;
    chk("man_inv_dout", 32'(dout_a), 32'h5A);
    chk("man_inv_cur", 32'(cur_a), 2);
    chk("man_inv_valid", 32'(valid_a), 1);
    cycle(1'b1, 1'b0, 2'd2, d, 4'b0000);
    @(posedge clk); #2;
    chk("man_noinv_dout", 32'(dout_a), 32'hA5);

    // Scan entered from manual: restart at channel 0.
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, 1'b1, 2'($urandom), $urandom, 4'($urandom));
      @(posedge clk); #2;
      chk("scan_seq_a", 32'(cur_a), 32'(exp_seq[k]));
      chk("scan_wrap_a", 32'(wrap_a), 32'(k == 7));
      chk("scan_seq_b", 32'(cur_b), 32'(k % 3));
      chk("scan_wrap_b", 32'(wrap_b), 32'(k % 3 == 2));
    end

    // Pause mid-scan and resume; two enabled cycles land instance a on channel 1.
    repeat (3) cycle(1'b0, 1'b1, 2'($urandom), $urandom, 4'($urandom));
    repeat (2) cycle(1'b1, 1'b1, 2'($urandom), $urandom, 4'($urandom));
    @(posedge clk); #2;
    chk("resume_cur_a", 32'(cur_a), 1);

    // One manual sample from sel=3, then scan restarts at channel 0.
    cycle(1'b1, 1'b0, 2'd3, $urandom, 4'($urandom));
    @(posedge clk); #2;
    chk("man_sel3_cur_a", 32'(cur_a), 3);
    chk("man_clamp_cur_b", 32'(cur_b), 2);
    chk("man_clamp_dout_b", 32'(dout_b), 32'(din[23:16] ^ {8{inv[2]}}));
    cycle(1'b1, 1'b1, 2'd3, $urandom, 4'($urandom));
    @(posedge clk); #2;
    chk("restart_cur_a", 32'(cur_a), 0);
    chk("restart_cur_b", 32'(cur_b), 0);

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(7) != 0), 1'($urandom_range(2) != 0),
            2'($urandom), $urandom, 4'($urandom));
    end

    // Asynchronous reset between edges.
    @(posedge clk); #3;
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    qa.delete();
    qb.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    repeat (3) cycle(1'b0, 1'($urandom), 2'($urandom), $urandom, 4'($urandom));
    repeat (2) cycle(1'b1, 1'b1, 2'($urandom), $urandom, 4'($urandom));
    @(posedge clk); #3;
    mon_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
